// File: rtl/axi_wdma_burst.sv
// Stream-to-AXI4 write DMA: splits one byte-addressed command into INCR bursts
// that never cross 4 KB, passes stream beats straight onto W and reports the first error response.
module axi_wdma_burst #(
    parameter int ADDRESS_BITS    = 32,
    parameter int LENGTH_BITS     = 32,
    parameter int DATA_BYTES      = 4,
    parameter int MAX_BURST       = 256,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic [ADDRESS_BITS-1:0]   cmd_address,
    input  logic [LENGTH_BITS-1:0]    cmd_bytes,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    output logic [1:0]                sts_resp,
    output logic                      sts_tlast_err,
    output logic                      sts_valid,
    input  logic                      sts_ready,
    output logic [3:0]                axi_m_awid,
    output logic [ADDRESS_BITS-1:0]   axi_m_awaddr,
    output logic [7:0]                axi_m_awlen,
    output logic [2:0]                axi_m_awsize,
    output logic [1:0]                axi_m_awburst,
    output logic                      axi_m_awvalid,
    input  logic                      axi_m_awready,
    output logic [8*DATA_BYTES-1:0]   axi_m_wdata,
    output logic [DATA_BYTES-1:0]     axi_m_wstrb,
    output logic                      axi_m_wlast,
    output logic                      axi_m_wvalid,
    input  logic                      axi_m_wready,
    input  logic [1:0]                axi_m_bresp,
    input  logic                      axi_m_bvalid,
    output logic                      axi_m_bready,
    input  logic [8*DATA_BYTES-1:0]   din_tdata,
    input  logic                      din_tlast,
    input  logic                      din_tvalid,
    output logic                      din_tready
);

    localparam int OFS_BITS = $clog2(DATA_BYTES);
    localparam int BW       = LENGTH_BITS + 1;
    localparam int PW       = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
    localparam int CW       = $clog2(MAX_OUTSTANDING + 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CALC   = 3'd1,
        S_ADDR   = 3'd2,
        S_DRAIN  = 3'd3,
        S_STATUS = 3'd4
    } state_t;

    state_t                  state_r, state_s;
    logic [ADDRESS_BITS-1:0] addr_r;
    logic [BW-1:0]           beats_left_r, total_beats_r, cmd_beat_r;
    logic [8:0]              burst_r;
    logic [DATA_BYTES-1:0]   first_mask_r, last_mask_r;
    logic [CW-1:0]           outstanding_r, fifo_cnt_r;
    logic [8:0]              fifo_mem_r [MAX_OUTSTANDING];
    logic [PW-1:0]           wr_ptr_r, rd_ptr_r;
    logic [7:0]              beat_idx_r;
    logic [1:0]              resp_r;
    logic                    tlast_err_r;

    logic                    cmd_hs_s, aw_hs_s, w_hs_s, b_hs_s, active_s, pop_s, cmd_last_s;
    logic [OFS_BITS-1:0]     offset_s, end_ofs_s;
    logic [BW-1:0]           total_s, to_4k_s, lim_s, burst_s;
    logic [8:0]              head_s;

    // Lanes at or above a byte offset within the bus word.
    function automatic logic [DATA_BYTES-1:0] lanes_from(input logic [OFS_BITS-1:0] ofs);
        lanes_from = {DATA_BYTES{1'b1}} << ofs;
    endfunction

    // Handshakes, command decode and burst sizing.
    always_comb begin
        cmd_hs_s   = cmd_valid && cmd_ready;
        aw_hs_s    = axi_m_awvalid && axi_m_awready;
        w_hs_s     = axi_m_wvalid && axi_m_wready;
        b_hs_s     = axi_m_bvalid && axi_m_bready;
        active_s   = (fifo_cnt_r != '0);
        head_s     = fifo_mem_r[rd_ptr_r];
        pop_s      = w_hs_s && axi_m_wlast;
        cmd_last_s = (cmd_beat_r == total_beats_r - BW'(1));
        offset_s   = cmd_address[OFS_BITS-1:0];
        end_ofs_s  = offset_s + cmd_bytes[OFS_BITS-1:0];
        total_s    = ({1'b0, cmd_bytes} + BW'(offset_s) + BW'(DATA_BYTES - 1)) >> OFS_BITS;
        to_4k_s    = (BW'(13'h1000) - BW'(addr_r[11:0])) >> OFS_BITS;
        lim_s      = (to_4k_s < BW'(MAX_BURST)) ? to_4k_s : BW'(MAX_BURST);
        burst_s    = (beats_left_r < lim_s) ? beats_left_r : lim_s;
    end

    // Interface outputs; W is a pass-through gated by a queued burst.
    always_comb begin
        cmd_ready     = (state_r == S_IDLE);
        sts_valid     = (state_r == S_STATUS);
        sts_resp      = resp_r;
        sts_tlast_err = tlast_err_r;
        axi_m_awid    = 4'd0;
        axi_m_awaddr  = addr_r;
        axi_m_awlen   = burst_r[7:0] - 8'd1;
        axi_m_awsize  = 3'(OFS_BITS);
        axi_m_awburst = 2'b01;
        axi_m_awvalid = (state_r == S_ADDR) && (outstanding_r < CW'(MAX_OUTSTANDING))
                        && (fifo_cnt_r < CW'(MAX_OUTSTANDING));
        axi_m_wvalid  = din_tvalid && active_s;
        din_tready    = axi_m_wready && active_s;
        axi_m_wdata   = din_tdata;
        axi_m_wlast   = active_s && ({1'b0, beat_idx_r} == head_s - 9'd1);
        axi_m_bready  = (outstanding_r != '0);
        axi_m_wstrb   = {DATA_BYTES{1'b1}};
        if (cmd_beat_r == '0) begin
            axi_m_wstrb = axi_m_wstrb & first_mask_r;
        end else begin
            axi_m_wstrb = axi_m_wstrb;
        end
        if (cmd_last_s) begin
            axi_m_wstrb = axi_m_wstrb & last_mask_r;
        end else begin
            axi_m_wstrb = axi_m_wstrb;
        end
    end

    // Address FSM next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            S_IDLE: begin
                if (cmd_hs_s) begin
                    state_s = (cmd_bytes == '0) ? S_STATUS : S_CALC;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_CALC: state_s = S_ADDR;
            S_ADDR: begin
                if (aw_hs_s) begin
                    state_s = (beats_left_r != '0) ? S_CALC : S_DRAIN;
                end else begin
                    state_s = S_ADDR;
                end
            end
            S_DRAIN: begin
                if ((outstanding_r == '0) && (fifo_cnt_r == '0)) begin
                    state_s = S_STATUS;
                end else begin
                    state_s = S_DRAIN;
                end
            end
            S_STATUS: begin
                if (sts_ready) begin
                    state_s = S_IDLE;
                end else begin
                    state_s = S_STATUS;
                end
            end
            default: state_s = S_IDLE;
        endcase
    end

    // FSM state register.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Command capture, burst sizing and address advance.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            addr_r        <= '0;
            beats_left_r  <= '0;
            total_beats_r <= '0;
            burst_r       <= 9'd0;
            first_mask_r  <= '0;
            last_mask_r   <= '0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (cmd_hs_s) begin
                        addr_r        <= {cmd_address[ADDRESS_BITS-1:OFS_BITS], {OFS_BITS{1'b0}}};
                        beats_left_r  <= total_s;
                        total_beats_r <= total_s;
                        first_mask_r  <= lanes_from(offset_s);
                        last_mask_r   <= (end_ofs_s == '0) ? {DATA_BYTES{1'b1}} : ~lanes_from(end_ofs_s);
                    end
                end
                S_CALC: begin
                    burst_r      <= burst_s[8:0];
                    beats_left_r <= beats_left_r - burst_s;
                end
                S_ADDR: begin
                    if (aw_hs_s) begin
                        addr_r <= addr_r + (ADDRESS_BITS'(burst_r) << OFS_BITS);
                    end
                end
                default: ;
            endcase
        end
    end

    // Outstanding-burst counter and the burst-length FIFO feeding the W path.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            outstanding_r <= '0;
            fifo_cnt_r    <= '0;
            wr_ptr_r      <= '0;
            rd_ptr_r      <= '0;
            beat_idx_r    <= 8'd0;
            for (int i = 0; i < MAX_OUTSTANDING; i++) begin
                fifo_mem_r[i] <= 9'd0;
            end
        end else begin
            case ({aw_hs_s, b_hs_s})
                2'b10:   outstanding_r <= outstanding_r + CW'(1);
                2'b01:   outstanding_r <= outstanding_r - CW'(1);
                default: outstanding_r <= outstanding_r;
            endcase
            case ({aw_hs_s, pop_s})
                2'b10:   fifo_cnt_r <= fifo_cnt_r + CW'(1);
                2'b01:   fifo_cnt_r <= fifo_cnt_r - CW'(1);
                default: fifo_cnt_r <= fifo_cnt_r;
            endcase
            if (aw_hs_s) begin
                fifo_mem_r[wr_ptr_r] <= burst_r;
                wr_ptr_r <= (wr_ptr_r == PW'(MAX_OUTSTANDING - 1)) ? '0 : wr_ptr_r + PW'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= (rd_ptr_r == PW'(MAX_OUTSTANDING - 1)) ? '0 : rd_ptr_r + PW'(1);
            end
            if (w_hs_s) begin
                beat_idx_r <= axi_m_wlast ? 8'd0 : beat_idx_r + 8'd1;
            end
        end
    end

    // Command beat position and status flags; tlast only flags, never steers counting.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            cmd_beat_r  <= '0;
            resp_r      <= 2'b00;
            tlast_err_r <= 1'b0;
        end else if (cmd_hs_s) begin
            cmd_beat_r  <= '0;
            resp_r      <= 2'b00;
            tlast_err_r <= 1'b0;
        end else begin
            if (w_hs_s) begin
                cmd_beat_r <= cmd_beat_r + BW'(1);
                if (din_tlast != cmd_last_s) begin
                    tlast_err_r <= 1'b1;
                end
            end
            if (b_hs_s && (axi_m_bresp != 2'b00) && (resp_r == 2'b00)) begin
                resp_r <= axi_m_bresp;
            end
        end
    end

endmodule

// File: doc/axi_wdma_burst.md
AXI_WDMA_BURST -- requirements
Module: axi_wdma_burst

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- ADDRESS_BITS, 32, AXI address width.
- LENGTH_BITS, 32, cmd_bytes width.
- DATA_BYTES, 4, bus width in bytes; legal values 4 or 8.
- MAX_BURST, 256, maximum beats per burst; legal range 1..256.
- MAX_OUTSTANDING, 4, maximum AW bursts accepted but not yet answered on B.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- aclk  in  1  clock.
- aresetn  in  1  reset: asynchronous, active-low; clock aclk.
- cmd_address  in  ADDRESS_BITS  byte start address; may be unaligned.
- cmd_bytes  in  LENGTH_BITS  transfer byte count.
- cmd_valid / cmd_ready  in / out  1  command handshake.
- sts_resp  out  2  first non-OKAY bresp seen, else 0.
- sts_tlast_err  out  1  din_tlast position mismatch.
- sts_valid / sts_ready  out / in  1  status handshake.
- axi_m_awid  out  4  constant 0.
- axi_m_awaddr  out  ADDRESS_BITS  burst address.
- axi_m_awlen  out  8  beats-1.
- axi_m_awsize  out  3  log2(DATA_BYTES).
- axi_m_awburst  out  2  constant INCR (01).
- axi_m_awvalid / axi_m_awready  out / in  1  write-address handshake.
- axi_m_wdata  out  8*DATA_BYTES  write data.
- axi_m_wstrb  out  DATA_BYTES  byte strobes.
- axi_m_wlast  out  1  last beat of burst.
- axi_m_wvalid / axi_m_wready  out / in  1  write-data handshake.
- axi_m_bresp  in  2  write response.
- axi_m_bvalid / axi_m_bready  in / out  1  write-response handshake.
- din_tdata  in  8*DATA_BYTES  stream data, already in memory byte lanes.
- din_tlast  in  1  end of stream.
- din_tvalid / din_tready  in / out  1  stream handshake.

Function
REQ-003 Command SHALL be accepted only on cmd_valid&&cmd_ready; cmd_ready SHALL be 1 only in IDLE.
REQ-004 Total beats SHALL be ceil((cmd_bytes + cmd_address mod DATA_BYTES)/DATA_BYTES), computed at LENGTH_BITS+1 width with no overflow.
REQ-005 cmd_bytes==0 SHALL issue no AXI traffic and SHALL go straight to STATUS with sts_resp=0 and sts_tlast_err=0.
REQ-006 Address FSM states SHALL be IDLE, CALC, ADDR, DRAIN, STATUS:
- IDLE -> CALC on command accept.
- CALC -> ADDR after one cycle.
- ADDR -> CALC on AW handshake while beats remain.
- ADDR -> DRAIN on AW handshake with no beats remaining.
- DRAIN -> STATUS when outstanding==0 and all W beats are done.
- STATUS -> IDLE on sts_ready.
REQ-007 Burst beats SHALL be min(remaining beats, MAX_BURST, beats up to the next 4 KB boundary); no burst SHALL cross a 4 KB boundary.
REQ-008 axi_m_awaddr SHALL be aligned down to DATA_BYTES; each subsequent burst SHALL start at previous awaddr + beats*DATA_BYTES.
REQ-009 axi_m_awvalid SHALL assert in ADDR only while outstanding<MAX_OUTSTANDING, and SHALL hold until awready.
REQ-010 Outstanding counter: +1 on AW handshake, -1 on B handshake, unchanged when both occur in the same cycle.
REQ-011 Each accepted burst's beat count SHALL be pushed into a FIFO of depth MAX_OUTSTANDING; the W path SHALL forward data only while that FIFO is non-empty.
REQ-012 W path SHALL be combinational pass-through: wvalid=din_tvalid&&active; din_tready=wready&&active; wdata=din_tdata.
REQ-013 axi_m_wlast SHALL assert on the beat whose index equals the head burst's beats-1; the FIFO SHALL pop on that handshake.
REQ-014 wstrb SHALL be all ones, except:
- first beat of a command: lanes below the address offset cleared;
- last beat of a command: lanes at or above the end offset cleared;
- a single-beat command: both masks applied.
REQ-015 sts_tlast_err SHALL set if din_tlast is seen before the command's last beat, or is absent on it; beat counting SHALL NOT be altered by din_tlast.
REQ-016 axi_m_bready SHALL be 1 whenever outstanding>0.
REQ-017 The first non-zero bresp SHALL be captured into sts_resp; later responses SHALL NOT overwrite it.
REQ-018 sts_valid SHALL be 1 only in STATUS and SHALL hold sts_resp and sts_tlast_err stable until sts_ready.
REQ-019 Status flags SHALL clear on command accept.

Reset
REQ-020 While aresetn is low, all of the following SHALL hold:
- cmd_ready=1;
- awvalid=0, wvalid=0, bready=0;
- sts_valid=0;
- din_tready=0;
- outstanding=0;
- FIFO empty;
- FSM in IDLE.
REQ-021 Reset asserted mid-transfer SHALL abort immediately with no status generated; resumption of an interrupted slave transaction SHALL NOT be required.

Verification
REQ-022 addr=0x1002, bytes=9, DATA_BYTES=4 -> one burst: awaddr=0x1000, awlen=2; wstrb 1100, 1111, 0111 (bit0=lowest address byte); status OKAY.
REQ-023 addr=0x0FF8, bytes=64 -> two bursts: 0x0FF8 len=1, then 0x1000 len=13; no 4 KB crossing.
REQ-024 bytes=4096, aligned, MAX_BURST=16, awready always 1, bvalid withheld -> exactly 4 AW handshakes before the stall; AW resumes on the first B.
REQ-025 Second bresp=SLVERR and fourth bresp=DECERR -> sts_resp=10 (SLVERR); transfer still completes.
REQ-026 din_tlast on beat 2 of 5 -> all 5 beats written and sts_tlast_err=1; bytes=0 -> sts_valid with no AW activity.
REQ-027 aresetn low during beat 3 of a burst -> all outputs at REQ-020 values in the same cycle; next command runs normally.
